// File: rtl/usb_pkt_pkg.sv
// Shared constants and types for the per-lane USB command packet parser.
// State codes are exported here so that benches can probe the parser state.
package usb_pkt_pkg;

    localparam logic [7:0] PREAMBLE = 8'hA5;

    typedef logic [7:0] byte_t;
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_TYPE    = 3'd1;
    localparam state_t ST_LEN     = 3'd2;
    localparam state_t ST_PAYLOAD = 3'd3;
    localparam state_t ST_CSUM    = 3'd4;
    localparam state_t ST_HOLD    = 3'd5;

    // One-cycle event pulses. The encoder never sets more than one bit per cycle.
    typedef struct packed {
        logic csum;
        logic len;
        logic timeout;
        logic drop;
    } evt_t;

endpackage

// File: rtl/usb_pkt_buf.sv
// Payload buffer: 2**AW x 8 simple dual-port RAM, one write port and one registered read port.
// A read of an address written in the same cycle returns the previous contents.
module usb_pkt_buf
    import usb_pkt_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] wr_addr_i,
    input  byte_t         wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output byte_t         rd_data_o
);

    byte_t mem_q [2**AW];
    byte_t rd_data_q;

    // Storage is deliberately left out of reset so that it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/usb_packet_parser.sv
// Frames one crossbar lane's byte stream into checked command packets and holds
// each good packet until the consumer acks it. Errors are reported as single-cycle pulses.
module usb_packet_parser
    import usb_pkt_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int AW      = 6,
    parameter int TIMEOUT = 1000
) (
    input  logic          c_i,
    input  logic          r_i,
    input  logic [7:0]    d_i,
    input  logic          dv_i,
    output logic          pkt_rdy_o,
    output logic [7:0]    pkt_type_o,
    output logic [7:0]    pkt_len_o,
    input  logic          pkt_ack_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    output logic          err_csum_o,
    output logic          err_len_o,
    output logic          err_timeout_o,
    output logic          drop_o
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam byte_t         LEN_MAX  = 8'(MAX_LEN);

    state_t        state_q, state_d;
    byte_t         sum_q, sum_d;
    logic [AW-1:0] idx_q, idx_d;
    byte_t         type_q, type_d;
    byte_t         len_q, len_d;
    byte_t         pkt_type_q, pkt_type_d;
    byte_t         pkt_len_q, pkt_len_d;
    logic [CW-1:0] tmo_q, tmo_d;
    evt_t          evt_q, evt_d;

    logic          buf_we;
    logic          in_packet;

    assign in_packet = (state_q == ST_TYPE) || (state_q == ST_LEN) ||
                       (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);

    // Next-state logic. The timeout check only fires on cycles without a byte,
    // so a byte arriving on the expiry cycle is processed and wins.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        type_d     = type_q;
        len_d      = len_q;
        pkt_type_d = pkt_type_q;
        pkt_len_d  = pkt_len_q;
        tmo_d      = tmo_q;
        evt_d      = '0;
        buf_we     = 1'b0;

        if (!in_packet || dv_i) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d         = '0;
            evt_d.timeout = 1'b1;
            state_d       = ST_IDLE;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                sum_d = '0;
                if (dv_i && d_i == PREAMBLE) begin
                    state_d = ST_TYPE;
                end
            end
            ST_TYPE: begin
                if (dv_i) begin
                    type_d  = d_i;
                    sum_d   = sum_q + d_i;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (dv_i) begin
                    len_d = d_i;
                    sum_d = sum_q + d_i;
                    if (d_i > LEN_MAX) begin
                        evt_d.len = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (d_i == 8'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (dv_i) begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + d_i;
                    idx_d  = idx_q + 1'b1;
                    if (8'(idx_q) == len_q - 8'd1) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (dv_i) begin
                    if (byte_t'(sum_q + d_i) == 8'd0) begin
                        pkt_type_d = type_q;
                        pkt_len_d  = len_q;
                        state_d    = ST_HOLD;
                    end else begin
                        evt_d.csum = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                // No preamble search here: every byte is dropped until the ack.
                if (dv_i) begin
                    evt_d.drop = 1'b1;
                end
                if (pkt_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge c_i or posedge r_i) begin
        if (r_i) begin
            state_q    <= ST_IDLE;
            sum_q      <= '0;
            idx_q      <= '0;
            type_q     <= '0;
            len_q      <= '0;
            pkt_type_q <= '0;
            pkt_len_q  <= '0;
            tmo_q      <= '0;
            evt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            type_q     <= type_d;
            len_q      <= len_d;
            pkt_type_q <= pkt_type_d;
            pkt_len_q  <= pkt_len_d;
            tmo_q      <= tmo_d;
            evt_q      <= evt_d;
        end
    end

    usb_pkt_buf #(
        .AW(AW)
    ) u_buf (
        .clk_i    (c_i),
        .rst_i    (r_i),
        .we_i     (buf_we),
        .wr_addr_i(idx_q),
        .wr_data_i(d_i),
        .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o)
    );

    assign pkt_rdy_o     = (state_q == ST_HOLD);
    assign pkt_type_o    = pkt_type_q;
    assign pkt_len_o     = pkt_len_q;
    assign err_csum_o    = evt_q.csum;
    assign err_len_o     = evt_q.len;
    assign err_timeout_o = evt_q.timeout;
    assign drop_o        = evt_q.drop;

endmodule

// File: tb/tb_usb_packet_parser.sv
// Directed bench for usb_packet_parser: a packet-level model checked every cycle,
// plus hand-computed expectations for the key packets.
module tb_usb_packet_parser;
    import usb_pkt_pkg::*;

    localparam int MAXL = 64;
    localparam int AWB  = 6;
    localparam int TMO  = 1000;

    logic           c = 1'b0;
    logic           r = 1'b1;
    logic [7:0]     d = 8'h00;
    logic           dv = 1'b0;
    logic           ack = 1'b0;
    logic [AWB-1:0] rdAddr = '0;
    logic           pktRdy;
    logic [7:0]     pktType;
    logic [7:0]     pktLen;
    logic [7:0]     rdData;
    logic           errCsum;
    logic           errLen;
    logic           errTmo;
    logic           drop;

    int total = 0;
    int bad   = 0;

    usb_packet_parser #(
        .MAX_LEN(MAXL),
        .AW     (AWB),
        .TIMEOUT(TMO)
    ) dut (
        .c_i          (c),
        .r_i          (r),
        .d_i          (d),
        .dv_i         (dv),
        .pkt_rdy_o    (pktRdy),
        .pkt_type_o   (pktType),
        .pkt_len_o    (pktLen),
        .pkt_ack_i    (ack),
        .rd_addr_i    (rdAddr),
        .rd_data_o    (rdData),
        .err_csum_o   (errCsum),
        .err_len_o    (errLen),
        .err_timeout_o(errTmo),
        .drop_o       (drop)
    );

    always #5 c = ~c;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: collects the bytes after the preamble and decides by byte count.
    logic [7:0] mBuf [MAXL];
    bit         mValid [MAXL];
    logic [7:0] mPkt [$];
    bit         mActive = 0;
    bit         mHold = 0;
    int         mIdle = 0;
    logic [7:0] mType = 8'h00;
    logic [7:0] mLen = 8'h00;
    bit         eCsum = 0;
    bit         eLen = 0;
    bit         eTmo = 0;
    bit         eDrop = 0;
    logic [7:0] eRd = 8'h00;
    bit         eRdValid = 1;

    always @(posedge c or posedge r) begin
        if (r) begin
            mActive = 0; mHold = 0; mIdle = 0; mType = 8'h00; mLen = 8'h00;
            eCsum = 0; eLen = 0; eTmo = 0; eDrop = 0; eRd = 8'h00; eRdValid = 1;
            mPkt.delete();
        end else begin
            int n;
            int s;
            eCsum = 0; eLen = 0; eTmo = 0; eDrop = 0;
            eRdValid = mValid[int'(rdAddr)];
            eRd = mBuf[int'(rdAddr)];
            if (mHold) begin
                if (dv) eDrop = 1;
                if (ack) mHold = 0;
            end else if (!mActive) begin
                if (dv && d == 8'hA5) begin
                    mActive = 1;
                    mIdle = 0;
                    mPkt.delete();
                end
            end else if (dv) begin
                mPkt.push_back(d);
                mIdle = 0;
                n = mPkt.size();
                if (n == 2 && int'(d) > MAXL) begin
                    eLen = 1;
                    mActive = 0;
                end else if (n >= 3 && n == int'(mPkt[1]) + 3) begin
                    s = 0;
                    foreach (mPkt[i]) s += int'(mPkt[i]);
                    if (s % 256 == 0) begin
                        mHold = 1;
                        mType = mPkt[0];
                        mLen = mPkt[1];
                    end else begin
                        eCsum = 1;
                    end
                    mActive = 0;
                end else if (n >= 3) begin
                    mBuf[n-3] = d;
                    mValid[n-3] = 1;
                end
            end else begin
                mIdle++;
                if (mIdle == TMO) begin
                    eTmo = 1;
                    mActive = 0;
                end
            end
            #1;
            checkOutput("model_rdy", 32'(pktRdy), 32'(mHold));
            checkOutput("model_type", 32'(pktType), 32'(mType));
            checkOutput("model_len", 32'(pktLen), 32'(mLen));
            checkOutput("model_err_csum", 32'(errCsum), 32'(eCsum));
            checkOutput("model_err_len", 32'(errLen), 32'(eLen));
            checkOutput("model_err_timeout", 32'(errTmo), 32'(eTmo));
            checkOutput("model_drop", 32'(drop), 32'(eDrop));
            if (eRdValid) checkOutput("model_rd_data", 32'(rdData), 32'(eRd));
        end
    end

    // One byte per call; back-to-back calls give one byte per cycle.
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge c);
        d = b;
        dv = 1'b1;
        @(posedge c);
        #1;
        dv = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge c);
        #1;
    endtask

    task automatic readByte(input logic [AWB-1:0] a, input logic [7:0] exp);
        @(negedge c);
        rdAddr = a;
        @(posedge c);
        #1;
        checkOutput("rd_data", 32'(rdData), 32'(exp));
    endtask

    task automatic ackPacket();
        @(negedge c);
        ack = 1'b1;
        @(posedge c);
        #1;
        ack = 1'b0;
        checkOutput("rdy_after_ack", 32'(pktRdy), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < MAXL; i++) mValid[i] = 0;
        #1;
        checkOutput("reset_rdy", 32'(pktRdy), 32'h0);
        checkOutput("reset_type", 32'(pktType), 32'h0);
        checkOutput("reset_rd_data", 32'(rdData), 32'h0);
        repeat (2) @(negedge c);
        r = 1'b0;

        // Good packet: 01+03+10+20+30+9C = 0x100.
        applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h03);
        applyStimulus(8'h10); applyStimulus(8'h20); applyStimulus(8'h30);
        applyStimulus(8'h9C);
        checkOutput("good_rdy", 32'(pktRdy), 32'h1);
        checkOutput("good_type", 32'(pktType), 32'h01);
        checkOutput("good_len", 32'(pktLen), 32'h03);
        readByte(6'd0, 8'h10);
        readByte(6'd1, 8'h20);
        readByte(6'd2, 8'h30);
        ackPacket();

        // Checksum off by one.
        applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h03);
        applyStimulus(8'h10); applyStimulus(8'h20); applyStimulus(8'h30);
        applyStimulus(8'h9D);
        checkOutput("csum_pulse", 32'(errCsum), 32'h1);
        checkOutput("csum_rdy", 32'(pktRdy), 32'h0);
        checkOutput("csum_state", 32'(dut.state_q), 32'(ST_IDLE));
        idleCycles(1);
        checkOutput("csum_pulse_end", 32'(errCsum), 32'h0);

        // Length over MAX_LEN, then a zero-length packet.
        applyStimulus(8'hA5); applyStimulus(8'h02); applyStimulus(8'h41);
        checkOutput("len_pulse", 32'(errLen), 32'h1);
        applyStimulus(8'hA5); applyStimulus(8'h02); applyStimulus(8'h00);
        applyStimulus(8'hFE);
        checkOutput("len0_rdy", 32'(pktRdy), 32'h1);
        checkOutput("len0_type", 32'(pktType), 32'h02);
        checkOutput("len0_len", 32'(pktLen), 32'h00);
        ackPacket();

        // Timeout on the 1000th idle cycle.
        applyStimulus(8'hA5); applyStimulus(8'h01);
        idleCycles(TMO - 1);
        checkOutput("tmo_early", 32'(errTmo), 32'h0);
        idleCycles(1);
        checkOutput("tmo_pulse", 32'(errTmo), 32'h1);

        // Byte landing on the expiry cycle wins.
        applyStimulus(8'hA5); applyStimulus(8'h01);
        idleCycles(TMO - 1);
        applyStimulus(8'h03);
        checkOutput("tmo_saved", 32'(errTmo), 32'h0);
        applyStimulus(8'h10); applyStimulus(8'h20); applyStimulus(8'h30);
        applyStimulus(8'h9C);
        checkOutput("tmo_saved_rdy", 32'(pktRdy), 32'h1);

        // Bytes during HOLD are dropped, including a preamble.
        applyStimulus(8'hA5);
        checkOutput("drop1", 32'(drop), 32'h1);
        applyStimulus(8'h02);
        checkOutput("drop2", 32'(drop), 32'h1);
        applyStimulus(8'h00);
        checkOutput("drop3", 32'(drop), 32'h1);
        checkOutput("drop_type", 32'(pktType), 32'h01);
        checkOutput("drop_len", 32'(pktLen), 32'h03);
        checkOutput("drop_rdy", 32'(pktRdy), 32'h1);
        @(negedge c);
        ack = 1'b1; d = 8'h55; dv = 1'b1;
        @(posedge c);
        #1;
        ack = 1'b0; dv = 1'b0;
        checkOutput("ack_drop", 32'(drop), 32'h1);
        checkOutput("ack_rdy", 32'(pktRdy), 32'h0);

        // Asynchronous reset mid-payload.
        rdAddr = 6'd0;
        applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h03);
        applyStimulus(8'h10);
        @(negedge c);
        #2;
        r = 1'b1;
        #1;
        checkOutput("arst_type", 32'(pktType), 32'h0);
        checkOutput("arst_len", 32'(pktLen), 32'h0);
        checkOutput("arst_rd_data", 32'(rdData), 32'h0);
        checkOutput("arst_rdy", 32'(pktRdy), 32'h0);
        @(negedge c);
        r = 1'b0;

        // 07+02+AA+55+F8 = 0x200.
        applyStimulus(8'hA5); applyStimulus(8'h07); applyStimulus(8'h02);
        applyStimulus(8'hAA); applyStimulus(8'h55); applyStimulus(8'hF8);
        checkOutput("post_rst_rdy", 32'(pktRdy), 32'h1);
        checkOutput("post_rst_type", 32'(pktType), 32'h07);
        checkOutput("post_rst_len", 32'(pktLen), 32'h02);
        readByte(6'd0, 8'hAA);
        readByte(6'd1, 8'h55);
        ackPacket();
        idleCycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
